oled_spi_tx: RTL

Write-only SPI byte transmitter that sits directly downstream of the SSD1306 step sequencer. It accepts one byte plus a D/C flag per valid/ready handshake and serialises it MSB-first in SPI mode 0 onto the OLED pins. Chip select is held low across back-to-back bytes. A one-cycle done pulse replaces the sequencer's old dependency on charreceived.

---
 rtl/ssd1306_pkg.sv | 32 +++
 rtl/oled_clk_phase.sv | 31 +++
 rtl/oled_spi_tx.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ssd1306_pkg.sv
// Shared definitions for the SSD1306 sequencer and its SPI byte transmitter.
// Holds the transmitter state encoding, the default SCLK divider and the command bytes.
package ssd1306_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_END,
    ST_HOLD
  } state_e;

  localparam int unsigned CLK_DIV_DEFAULT = 4;

  localparam logic [7:0] CMD_DISPLAY_OFF    = 8'hAE;
  localparam logic [7:0] CMD_DISPLAY_ON     = 8'hAF;
  localparam logic [7:0] CMD_SET_CONTRAST   = 8'h81;
  localparam logic [7:0] CMD_CHARGE_PUMP    = 8'h8D;
  localparam logic [7:0] CMD_SET_MUX        = 8'hA8;
  localparam logic [7:0] CMD_SET_OFFSET     = 8'hD3;
  localparam logic [7:0] CMD_START_LINE     = 8'h40;
  localparam logic [7:0] CMD_SEG_REMAP      = 8'hA1;
  localparam logic [7:0] CMD_COM_SCAN_DEC   = 8'hC8;
  localparam logic [7:0] CMD_SET_COM_PINS   = 8'hDA;
  localparam logic [7:0] CMD_SET_CLK_DIV    = 8'hD5;
  localparam logic [7:0] CMD_SET_PRECHARGE  = 8'hD9;
  localparam logic [7:0] CMD_SET_VCOM       = 8'hDB;
  localparam logic [7:0] CMD_RESUME_RAM     = 8'hA4;
  localparam logic [7:0] CMD_NORMAL_DISPLAY = 8'hA6;
  localparam logic [7:0] CMD_MEM_MODE       = 8'h20;

endpackage

// File: rtl/oled_clk_phase.sv
// SCLK phase timer: counts the cycles of the current SCLK half-period and strobes
// o_phase_end on its last cycle. Held cleared whenever i_run is low.
module oled_clk_phase
  import ssd1306_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk_50M,
  input  logic rst_n,
  input  logic i_run,
  output logic o_phase_end
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_div_cnt;

  assign o_phase_end = i_run && (r_div_cnt == LAST_CNT);

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (!i_run || o_phase_end) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/oled_spi_tx.sv
// Write-only SPI (mode 0) byte transmitter for the SSD1306: valid/ready in, MSB-first out,
// chip select held low across back-to-back words, one-cycle done pulse per word.
module oled_spi_tx
  import ssd1306_pkg::*;
#(
  parameter int unsigned CLK_DIV  = CLK_DIV_DEFAULT,
  parameter int unsigned WORD_LEN = 8
) (
  input  logic                clk_50M,
  input  logic                rst_n,
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic [WORD_LEN-1:0] tx_data,
  input  logic                tx_dc,
  output logic                oled_sclk,
  output logic                oled_sdin,
  output logic                oled_dc,
  output logic                oled_cs_n,
  output logic                busy,
  output logic                done
);

  localparam int unsigned BW = $clog2(WORD_LEN + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_LEN - 1);

  state_e              r_state, w_state_d;
  logic [WORD_LEN-1:0] r_shreg, w_shreg_d, w_shift;
  logic [BW-1:0]       r_bit_cnt, w_bit_cnt_d;
  logic                r_sclk, w_sclk_d;
  logic                r_sdin, w_sdin_d;
  logic                r_dc, w_dc_d;
  logic                r_cs_n, w_cs_n_d;
  logic                r_done, w_done_d;
  logic                w_accept, w_run, w_phase_end;

  assign tx_ready  = (r_state == ST_IDLE) || (r_state == ST_END);
  assign busy      = (r_state != ST_IDLE);
  assign w_accept  = tx_valid && tx_ready;
  assign w_run     = (r_state == ST_LOW) || (r_state == ST_HIGH) || (r_state == ST_HOLD);
  assign w_shift   = r_shreg << 1;

  assign oled_sclk = r_sclk;
  assign oled_sdin = r_sdin;
  assign oled_dc   = r_dc;
  assign oled_cs_n = r_cs_n;
  assign done      = r_done;

  oled_clk_phase #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_phase (
    .clk_50M    (clk_50M),
    .rst_n      (rst_n),
    .i_run      (w_run),
    .o_phase_end(w_phase_end)
  );

  always_comb begin
    w_state_d   = r_state;
    w_shreg_d   = r_shreg;
    w_bit_cnt_d = r_bit_cnt;
    w_sclk_d    = r_sclk;
    w_sdin_d    = r_sdin;
    w_dc_d      = r_dc;
    w_cs_n_d    = r_cs_n;
    w_done_d    = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_END: begin
        if (w_accept) begin
          w_state_d   = ST_LOW;
          w_shreg_d   = tx_data;
          w_bit_cnt_d = '0;
          w_sdin_d    = tx_data[WORD_LEN-1];
          w_dc_d      = tx_dc;
          w_cs_n_d    = 1'b0;
        end else if (r_state == ST_END) begin
          w_state_d = ST_HOLD;
        end
      end
      ST_LOW: begin
        if (w_phase_end) begin
          w_state_d = ST_HIGH;
          w_sclk_d  = 1'b1;
        end
      end
      ST_HIGH: begin
        if (w_phase_end) begin
          w_sclk_d = 1'b0;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_d = ST_END;
            w_done_d  = 1'b1;
          end else begin
            w_state_d   = ST_LOW;
            w_shreg_d   = w_shift;
            w_sdin_d    = w_shift[WORD_LEN-1];
            w_bit_cnt_d = r_bit_cnt + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        // Keep CS asserted one extra half-period after the last falling edge.
        if (w_phase_end) begin
          w_state_d = ST_IDLE;
          w_cs_n_d  = 1'b1;
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_sclk    <= 1'b0;
      r_sdin    <= 1'b0;
      r_dc      <= 1'b0;
      r_cs_n    <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_shreg   <= w_shreg_d;
      r_bit_cnt <= w_bit_cnt_d;
      r_sclk    <= w_sclk_d;
      r_sdin    <= w_sdin_d;
      r_dc      <= w_dc_d;
      r_cs_n    <= w_cs_n_d;
      r_done    <= w_done_d;
    end
  end

endmodule
